frame_buf_rd_ctrl: RTL
======================

FRAME_BUF_RD_CTRL -- requirements
Module: frame_buf_rd_ctrl

Interface
REQ-001 SHALL have parameter REG_WD, default 32, width of the geometry/timing register inputs.
REQ-002 SHALL have parameter DATA_WD, default 16, pixel word width.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_frame_start  input  1  one-cycle request to emit one frame.
REQ-006 SHALL have port iv_roi_width  input  REG_WD  pixels per line.
REQ-007 SHALL have port iv_roi_height  input  REG_WD  lines per frame.
REQ-008 SHALL have port iv_h_blank  input  REG_WD  lval-low cycles between lines.
REQ-009 SHALL have port iv_fv_lead  input  REG_WD  cycles from fval rise to first lval, and from last lval fall to fval fall.
REQ-010 SHALL have port i_buf_empty  input  1  show-ahead buffer empty.
REQ-011 SHALL have port iv_buf_dout  input  DATA_WD  buffer head word, valid when i_buf_empty=0.
REQ-012 SHALL have port o_buf_rd  output  1  buffer pop strobe.
REQ-013 SHALL have ports o_fval, o_lval  output  1 each  frame/line valid.
REQ-014 SHALL have port ov_pix_data  output  DATA_WD  pixel data, meaningful only when o_lval=1.
REQ-015 SHALL have port o_busy  output  1  high from accepted start until return to IDLE.
REQ-016 SHALL have port o_underflow  output  1  sticky, set on any stall cycle inside a line.

Function
REQ-017 SHALL implement states IDLE, LEAD, LINE, HBLANK, TAIL.
REQ-018 IDLE->LEAD SHALL occur when i_frame_start=1 and width!=0 and height!=0; start with zero width or height SHALL be ignored.
REQ-019 Width, height, h_blank, fv_lead SHALL be latched on the accepted start; changes mid-frame have no effect on that frame.
REQ-020 i_frame_start while not IDLE SHALL be ignored (no queuing).
REQ-021 o_fval SHALL be registered, rising the cycle after an accepted start, falling on exit from TAIL.
REQ-022 LEAD SHALL last fv_lead cycles (0 = go directly to LINE), then LINE.
REQ-023 In LINE, o_buf_rd SHALL equal !i_buf_empty (combinational); each pop increments the pixel counter.
REQ-024 o_lval and ov_pix_data SHALL be registered: one cycle after a pop, o_lval=1 and ov_pix_data=popped word; cycles without pop give o_lval=0.
REQ-025 An empty cycle inside LINE (pixel count < width) SHALL be a stall: no pop, o_lval=0 next cycle, o_underflow set.
REQ-026 After the width-th pop, state SHALL leave LINE; line counter increments; if lines < height go to HBLANK, else TAIL.
REQ-027 HBLANK SHALL last h_blank cycles (0 = back-to-back lines, lval continuous across lines), then LINE.
REQ-028 TAIL SHALL last fv_lead cycles counted after the final o_lval falls, then IDLE with o_fval=0.
REQ-029 o_buf_rd SHALL be 0 in every state other than LINE; never more than width pops per line, never more than width*height per frame.
REQ-030 Counters SHALL be REG_WD wide; no wrap within a legal frame.
REQ-031 o_busy SHALL be 1 in every state except IDLE.
REQ-032 o_underflow SHALL clear only on reset.

Reset
REQ-033 On reset: state IDLE; o_fval, o_lval, o_buf_rd, o_busy, o_underflow = 0; ov_pix_data = 0; all counters 0.
REQ-034 Reset asserted mid-frame SHALL drive o_fval and o_lval low on the next clock edge with no further pops; after release, block waits for a new start.

Verification
REQ-035 16x16, h_blank=4, fv_lead=3, buffer always non-empty, one start -> fval high 1+3+16*16+15*4+3 cycles span, 16 lval pulses of 16 cycles, 256 pops, data in pop order, o_underflow=0.
REQ-036 Same geometry, buffer empty for 5 cycles in line 2 pixel 8 -> lval gap of 5 cycles, line still 16 pixels, o_underflow=1, total pops 256.
REQ-037 h_blank=0, fv_lead=0, 4x2 -> fval rises cycle after start, lval continuous 8 cycles, fval falls right after last pixel.
REQ-038 Start with width=0 -> o_busy stays 0, no fval, no pops; start pulsed mid-frame -> exactly one frame emitted.
REQ-039 Reset asserted at line 5 of 16x16 -> fval/lval low next edge, o_buf_rd=0, o_underflow=0; subsequent start emits full clean frame.
REQ-040 Change iv_roi_width from 16 to 8 mid-frame -> current frame keeps 16-pixel lines; next frame uses 8.

Source files
------------

// File: rtl/frame_buf_rd_ctrl.sv
// Frame readout controller: drains a show-ahead pixel buffer into fval/lval-framed
// video using a geometry latched when the frame starts.
module frame_buf_rd_ctrl #(
  parameter int unsigned REG_WD  = 32,
  parameter int unsigned DATA_WD = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_frame_start,
  input  logic [REG_WD-1:0]  iv_roi_width,
  input  logic [REG_WD-1:0]  iv_roi_height,
  input  logic [REG_WD-1:0]  iv_h_blank,
  input  logic [REG_WD-1:0]  iv_fv_lead,
  input  logic               i_buf_empty,
  input  logic [DATA_WD-1:0] iv_buf_dout,
  output logic               o_buf_rd,
  output logic               o_fval,
  output logic               o_lval,
  output logic [DATA_WD-1:0] ov_pix_data,
  output logic               o_busy,
  output logic               o_underflow
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD   = 3'd1,
    LINE   = 3'd2,
    HBLANK = 3'd3,
    TAIL   = 3'd4
  } state_t;

  state_t             state;
  logic [REG_WD-1:0]  width_q;
  logic [REG_WD-1:0]  height_q;
  logic [REG_WD-1:0]  hblank_q;
  logic [REG_WD-1:0]  lead_q;
  logic [REG_WD-1:0]  pix_cnt;
  logic [REG_WD-1:0]  line_cnt;
  logic [REG_WD-1:0]  tmr;

  logic               pop_c;
  logic               start_ok_c;
  logic [REG_WD-1:0]  pix_nxt_c;
  logic [REG_WD-1:0]  line_nxt_c;
  logic [REG_WD-1:0]  tmr_nxt_c;

  // Pop is gated by reset so a mid-frame reset cannot steal a word from the buffer.
  assign pop_c      = (state == LINE) && !i_buf_empty && !reset;
  assign o_buf_rd   = pop_c;
  assign start_ok_c = i_frame_start && (iv_roi_width != '0) && (iv_roi_height != '0);
  assign pix_nxt_c  = pix_cnt + REG_WD'(1);
  assign line_nxt_c = line_cnt + REG_WD'(1);
  assign tmr_nxt_c  = tmr + REG_WD'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      width_q     <= '0;
      height_q    <= '0;
      hblank_q    <= '0;
      lead_q      <= '0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      tmr         <= '0;
      o_fval      <= 1'b0;
      o_lval      <= 1'b0;
      ov_pix_data <= '0;
      o_busy      <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_lval <= pop_c;
      if (pop_c) begin
        ov_pix_data <= iv_buf_dout;
      end

      case (state)
        IDLE: begin
          if (start_ok_c) begin
            width_q  <= iv_roi_width;
            height_q <= iv_roi_height;
            hblank_q <= iv_h_blank;
            lead_q   <= iv_fv_lead;
            pix_cnt  <= '0;
            line_cnt <= '0;
            tmr      <= '0;
            o_fval   <= 1'b1;
            o_busy   <= 1'b1;
            state    <= (iv_fv_lead == '0) ? LINE : LEAD;
          end
        end

        LEAD: begin
          if (tmr_nxt_c == lead_q) begin
            tmr   <= '0;
            state <= LINE;
          end else begin
            tmr <= tmr_nxt_c;
          end
        end

        // An empty cycle here is always mid-line: the state leaves LINE on the last pop.
        LINE: begin
          if (!pop_c) begin
            o_underflow <= 1'b1;
          end else if (pix_nxt_c == width_q) begin
            pix_cnt  <= '0;
            line_cnt <= line_nxt_c;
            tmr      <= '0;
            if (line_nxt_c == height_q) begin
              state <= TAIL;
            end else if (hblank_q != '0) begin
              state <= HBLANK;
            end
          end else begin
            pix_cnt <= pix_nxt_c;
          end
        end

        HBLANK: begin
          if (tmr_nxt_c == hblank_q) begin
            tmr   <= '0;
            state <= LINE;
          end else begin
            tmr <= tmr_nxt_c;
          end
        end

        // First TAIL cycle carries the final lval; fv_lead more cycles follow it.
        TAIL: begin
          if (tmr == lead_q) begin
            tmr    <= '0;
            o_fval <= 1'b0;
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            tmr <= tmr_nxt_c;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
